tx_egress_arbiter: RTL and testbench
====================================

Name: tx_egress_arbiter

Overview:
Packet-atomic, two-input round-robin arbiter that merges the card-to-peer response stream (input 0) and the card-to-host ack stream (input 1) onto one shared UDP transmit port.
Each stream carries 512-bit data, keep, last and src/dst/size sidebands.
Once a source is granted, the grant holds until that packet's last beat, so packets never interleave.
A single registered output stage gives full throughput, and per-source packet counters support debug.

Parameters:
DATA_WIDTH, 512, tdata width
KEEP_WIDTH, 64, tkeep width (DATA_WIDTH/8)
META_WIDTH, 16, width of each of src, dst, size
CNT_WIDTH, 32, width of the per-source packet counters

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
s0_valid  in  1  input 0 (card-to-peer) beat valid
s0_data  in  DATA_WIDTH  input 0 data
s0_keep  in  KEEP_WIDTH  input 0 keep
s0_last  in  1  input 0 last beat of packet
s0_src / s0_dst / s0_size  in  META_WIDTH each  input 0 sidebands
s0_ready  out  1  input 0 ready
s1_valid, s1_data, s1_keep, s1_last, s1_src, s1_dst, s1_size  in  as s0  input 1 (card-to-host)
s1_ready  out  1  input 1 ready
m_valid  out  1  merged output valid
m_data / m_keep / m_last / m_src / m_dst / m_size  out  as inputs  merged output
m_ready  in  1  downstream ready
m_grant  out  1  source index of the beat currently held in the output register
pkt_cnt0 / pkt_cnt1  out  CNT_WIDTH  completed packets forwarded from each source (count of last beats)

Behaviour:
Reset (asynchronous, rst_n=0):
- m_valid=0; m_data, m_keep, m_last, m_src, m_dst, m_size, m_grant all 0.
- FSM to IDLE; rr_last=1, so input 0 wins the first contention.
- pkt_cnt0 and pkt_cnt1 to 0.
- s0_ready and s1_ready are 0 while reset is asserted.

Output register:
- load = !m_valid || m_ready.
- A beat from the selected source transfers when sel_valid && load.
- On transfer, all fields, including that beat's sidebands, are registered and m_valid is set to 1.
- If m_ready=1 and there is no transfer, m_valid goes to 0.
- Latency is one cycle from input handshake to m_valid. Throughput is one beat per cycle with no bubbles, including between packets.

Grant and ready:
- sx_ready = load && (grant == x). The unselected source always sees ready=0.

FSM states: IDLE, LOCK0, LOCK1.
- IDLE: combinational choice in the same cycle.
  - Only s0_valid: grant 0. Only s1_valid: grant 1.
  - Both valid: grant !rr_last.
  - The first beat transfers in the same cycle if load=1.
  - If that beat is not last, move to LOCKx. If it is last, stay in IDLE.
  - rr_last is updated to x on every first-beat transfer.
- LOCKx: grant fixed to x regardless of the other input's valid.
  - Return to IDLE on a transfer with sx_last=1.
  - A stall (load=0 or sx_valid=0) holds the state. No timeout.
- Single-beat packets arriving on both inputs every cycle must alternate 0,1,0,1 with no idle cycles.
- An idle input never blocks the other. No grant is issued to an input with valid=0.

Counters:
- pkt_cntx increments on a transfer of a last beat from x.
- Counters wrap modulo 2^CNT_WIDTH.
- Both counters may increment in the same run but never in the same cycle, since only one transfer per cycle is possible.

Protocol assumptions enforced by assertions, not by logic:
- Inputs hold data and sidebands stable while valid && !ready.
- m_* outputs are stable while m_valid && !m_ready.

Reset mid-packet:
- The lock is dropped and the partial packet is discarded downstream of the block.
- After reset, arbitration restarts in IDLE.

Decomposition:
- Shared package (the existing UDP/KV package): arb_state_e enum {IDLE, LOCK0, LOCK1} and a tx_beat_t struct {data, keep, last, src, dst, size} sized from the package width constants.
- Sub-module axis_reg_slice (output register with the load rule above), parameterised on the width of tx_beat_t.
- The arbiter FSM and counters stay in the top module.

Test Plan:
1. Reset, then 3-beat packet on s0 only (size=0x00C0, src=0x1234), m_ready=1 -> m_valid from cycle 1, three beats, m_last on the third, pkt_cnt0=1, s1_ready stays 0.
2. Both inputs present 4-beat packets from cycle 0, m_ready=1 -> all s0 beats (rr_last=1 after reset), then s1 beats contiguous with no gap; m_grant 0,0,0,0,1,1,1,1.
3. Continuous single-beat packets on both inputs for 20 cycles -> strict 0/1 alternation; pkt_cnt0=pkt_cnt1=10.
4. s1 mid-packet (beat 2 of 5) while s0 asserts valid; random m_ready backpressure at 50% -> no interleave, s0 granted only after s1_last, output fields stable during stalls.
5. s0 drops valid for 3 cycles mid-packet while s1_valid=1 -> output bubbles, s1_ready=0 until s0 finishes.
6. Assert rst_n=0 asynchronously mid-packet -> m_valid=0 and counters=0 immediately; after release, the next contention grants s0.

Source files
------------

// File: rtl/tx_egress_arbiter_pkg.sv
// Shared types for the UDP transmit path: arbiter states and the egress beat record.
package tx_egress_arbiter_pkg;

  localparam int DATA_WIDTH = 512;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int META_WIDTH = 16;
  localparam int CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [META_WIDTH-1:0] src;
    logic [META_WIDTH-1:0] dst;
    logic [META_WIDTH-1:0] size;
  } tx_beat_t;

  localparam int TX_BEAT_W = $bits(tx_beat_t);

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage forward register slice: loads whenever empty or being drained,
// so back-to-back beats pass with no bubbles.
module axis_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_load,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign o_load  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // NOTE: the payload register is reset too, because the merged output fields
  // must read as zero after reset; state is updated with <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_valid && o_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_egress_arbiter.sv
// Packet-atomic two-input round-robin merge of the card-to-peer (0) and
// card-to-host ack (1) streams onto the shared UDP transmit port.
module tx_egress_arbiter
  import tx_egress_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s0_valid,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic [KEEP_WIDTH-1:0] s0_keep,
  input  logic                  s0_last,
  input  logic [META_WIDTH-1:0] s0_src,
  input  logic [META_WIDTH-1:0] s0_dst,
  input  logic [META_WIDTH-1:0] s0_size,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic [KEEP_WIDTH-1:0] s1_keep,
  input  logic                  s1_last,
  input  logic [META_WIDTH-1:0] s1_src,
  input  logic [META_WIDTH-1:0] s1_dst,
  input  logic [META_WIDTH-1:0] s1_size,
  output logic                  s1_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [KEEP_WIDTH-1:0] m_keep,
  output logic                  m_last,
  output logic [META_WIDTH-1:0] m_src,
  output logic [META_WIDTH-1:0] m_dst,
  output logic [META_WIDTH-1:0] m_size,
  input  logic                  m_ready,
  output logic                  m_grant,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

  arb_state_e           r_state;
  logic                 r_rr_last;
  logic [CNT_WIDTH-1:0] r_cnt0;
  logic [CNT_WIDTH-1:0] r_cnt1;

  tx_beat_t             w_beat0;
  tx_beat_t             w_beat1;
  tx_beat_t             w_sel_beat;
  tx_beat_t             w_out_beat;
  logic                 w_grant;
  logic                 w_sel_valid;
  logic                 w_load;
  logic                 w_xfer;
  logic [TX_BEAT_W:0]   w_out_data;

  assign w_beat0 = '{data: s0_data, keep: s0_keep, last: s0_last,
                     src: s0_src, dst: s0_dst, size: s0_size};
  assign w_beat1 = '{data: s1_data, keep: s1_keep, last: s1_last,
                     src: s1_src, dst: s1_dst, size: s1_size};

  // In IDLE the choice is made combinationally so a first beat moves in the same cycle.
  always_comb begin
    w_grant = 1'b0;
    case (r_state)
      IDLE:    w_grant = (s0_valid && s1_valid) ? !r_rr_last : s1_valid;
      LOCK0:   w_grant = 1'b0;
      LOCK1:   w_grant = 1'b1;
      default: w_grant = 1'b0;
    endcase
  end

  assign w_sel_valid = w_grant ? s1_valid : s0_valid;
  assign w_sel_beat  = w_grant ? w_beat1  : w_beat0;
  assign w_xfer      = w_sel_valid && w_load;

  // Readies are forced low while reset is held, even though the slice reports load=1.
  assign s0_ready = rst_n && w_load && !w_grant;
  assign s1_ready = rst_n && w_load &&  w_grant;

  axis_reg_slice #(
    .WIDTH (TX_BEAT_W + 1)
  ) u_out_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_sel_valid),
    .i_data  ({w_grant, w_sel_beat}),
    .o_load  (w_load),
    .o_valid (m_valid),
    .o_data  (w_out_data),
    .i_ready (m_ready)
  );

  assign {m_grant, w_out_beat} = w_out_data;
  assign m_data = w_out_beat.data;
  assign m_keep = w_out_beat.keep;
  assign m_last = w_out_beat.last;
  assign m_src  = w_out_beat.src;
  assign m_dst  = w_out_beat.dst;
  assign m_size = w_out_beat.size;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_rr_last <= w_grant;
            if (!w_sel_beat.last) r_state <= w_grant ? LOCK1 : LOCK0;
          end
        end
        LOCK0, LOCK1: begin
          if (w_xfer && w_sel_beat.last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_xfer && w_sel_beat.last) begin
      if (w_grant) r_cnt1 <= r_cnt1 + 1'b1;
      else         r_cnt0 <= r_cnt0 + 1'b1;
    end
  end

  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;

  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready) |=> $stable(w_out_data));
  a_s0_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (s0_valid && !s0_ready) |=> (s0_valid && $stable(w_beat0)));
  a_s1_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (s1_valid && !s1_ready) |=> (s1_valid && $stable(w_beat1)));

endmodule

// File: tb/tb_tx_egress_arbiter.sv
// Directed bench for tx_egress_arbiter: per-cycle vector tables plus hand-written
// sequences for alternation, backpressure and asynchronous reset.
module tb_tx_egress_arbiter;
  import tx_egress_arbiter_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  s0_valid = 1'b0, s0_last = 1'b0, s0_ready;
  logic [DATA_WIDTH-1:0] s0_data = '0;
  logic [KEEP_WIDTH-1:0] s0_keep = '1;
  logic [META_WIDTH-1:0] s0_src = 16'h1234, s0_dst = 16'hAAAA, s0_size = 16'h00C0;
  logic                  s1_valid = 1'b0, s1_last = 1'b0, s1_ready;
  logic [DATA_WIDTH-1:0] s1_data = '0;
  logic [KEEP_WIDTH-1:0] s1_keep = 64'h0000_0000_0000_00FF;
  logic [META_WIDTH-1:0] s1_src = 16'h5678, s1_dst = 16'hBBBB, s1_size = 16'h0040;
  logic                  m_valid, m_last, m_grant, m_ready = 1'b0;
  logic [DATA_WIDTH-1:0] m_data;
  logic [KEEP_WIDTH-1:0] m_keep;
  logic [META_WIDTH-1:0] m_src, m_dst, m_size;
  logic [CNT_WIDTH-1:0]  pkt_cnt0, pkt_cnt1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  tx_egress_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_keep(s0_keep), .s0_last(s0_last),
    .s0_src(s0_src), .s0_dst(s0_dst), .s0_size(s0_size), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_keep(s1_keep), .s1_last(s1_last),
    .s1_src(s1_src), .s1_dst(s1_dst), .s1_size(s1_size), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .m_src(m_src), .m_dst(m_dst), .m_size(m_size), .m_ready(m_ready),
    .m_grant(m_grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  // One cycle: inputs, readies expected this cycle, output register expected after the edge.
  typedef struct packed {
    logic s0v, s0l; logic [15:0] s0t;
    logic s1v, s1l; logic [15:0] s1t;
    logic mr;
    logic e0r, e1r;
    logic emv, emg, eml; logic [15:0] emt;
  } vec_t;

  typedef struct {
    logic [15:0] tag;
    logic        grant;
    logic        last;
  } exp_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s0v, logic s0l, logic [15:0] s0t,
                              logic s1v, logic s1l, logic [15:0] s1t, logic mr,
                              logic e0r, logic e1r,
                              logic emv, logic emg, logic eml, logic [15:0] emt);
    return '{s0v, s0l, s0t, s1v, s1l, s1t, mr, e0r, e1r, emv, emg, eml, emt};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n    = 1'b0;
    s0_valid = 1'b0; s0_last = 1'b0; s0_data = '0;
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = '0;
    m_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    @(negedge clk);
    s0_valid = v.s0v; s0_last = v.s0l; s0_data = DATA_WIDTH'(v.s0t);
    s1_valid = v.s1v; s1_last = v.s1l; s1_data = DATA_WIDTH'(v.s1t);
    m_ready  = v.mr;
    #1;
    check({name, " s0_ready"}, s0_ready, v.e0r);
    check({name, " s1_ready"}, s1_ready, v.e1r);
    @(posedge clk);
    #1;
    check({name, " m_valid"}, m_valid, v.emv);
    if (v.emv) begin
      check({name, " m_grant"}, m_grant, v.emg);
      check({name, " m_last"}, m_last, v.eml);
      check({name, " m_data"}, m_data[15:0], v.emt);
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  initial begin
    logic [15:0] tag0, tag1;
    logic        h0, h1, stall_prev;
    logic [15:0] sv_tag;
    logic        sv_grant, sv_last;
    int          i0, i1, cyc;
    exp_t        exp_q[$];
    exp_t        e;

    // Reset state, with downstream ready so only reset can hold the readies low.
    m_ready = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1;
    #3;
    check("rst s0_ready", s0_ready, 1'b0);
    check("rst s1_ready", s1_ready, 1'b0);
    check("rst m_valid", m_valid, 1'b0);
    check("rst m_grant", m_grant, 1'b0);
    check("rst m_data", m_data[63:0], 64'd0);
    check("rst m_size", m_size, 16'd0);
    check("rst cnt0", pkt_cnt0, 0);
    check("rst cnt1", pkt_cnt1, 0);
    reset_dut();

    // 1: three-beat packet on s0 alone.
    tbl.push_back(mk(1,0,16'h0001, 0,0,16'h0, 1, 1,0, 1,0,0,16'h0001));
    tbl.push_back(mk(1,0,16'h0002, 0,0,16'h0, 1, 1,0, 1,0,0,16'h0002));
    tbl.push_back(mk(1,1,16'h0003, 0,0,16'h0, 1, 1,0, 1,0,1,16'h0003));
    tbl.push_back(mk(0,0,16'h0000, 0,0,16'h0, 1, 1,0, 0,0,0,16'h0000));
    run_table("t1");
    check("t1 cnt0", pkt_cnt0, 1);
    check("t1 cnt1", pkt_cnt1, 0);
    check("t1 m_src", m_src, 16'h1234);
    check("t1 m_size", m_size, 16'h00C0);
    check("t1 m_dst", m_dst, 16'hAAAA);

    // 2: contention from reset, s0 wins, s1 follows with no gap.
    reset_dut();
    tbl.push_back(mk(1,0,16'h0011, 1,0,16'h0021, 1, 1,0, 1,0,0,16'h0011));
    tbl.push_back(mk(1,0,16'h0012, 1,0,16'h0021, 1, 1,0, 1,0,0,16'h0012));
    tbl.push_back(mk(1,0,16'h0013, 1,0,16'h0021, 1, 1,0, 1,0,0,16'h0013));
    tbl.push_back(mk(1,1,16'h0014, 1,0,16'h0021, 1, 1,0, 1,0,1,16'h0014));
    tbl.push_back(mk(0,0,16'h0000, 1,0,16'h0021, 1, 0,1, 1,1,0,16'h0021));
    tbl.push_back(mk(0,0,16'h0000, 1,0,16'h0022, 1, 0,1, 1,1,0,16'h0022));
    tbl.push_back(mk(0,0,16'h0000, 1,0,16'h0023, 1, 0,1, 1,1,0,16'h0023));
    tbl.push_back(mk(0,0,16'h0000, 1,1,16'h0024, 1, 0,1, 1,1,1,16'h0024));
    tbl.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 1, 1,0, 0,0,0,16'h0000));
    run_table("t2");
    check("t2 cnt0", pkt_cnt0, 1);
    check("t2 cnt1", pkt_cnt1, 1);
    check("t2 m_src", m_src, 16'h5678);
    check("t2 m_keep", m_keep, 64'h00FF);

    // 3: single-beat packets on both inputs every cycle alternate 0,1,0,1.
    reset_dut();
    tag0 = 16'h0100; tag1 = 16'h0200;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      s0_valid = 1'b1; s0_last = 1'b1; s0_data = DATA_WIDTH'(tag0);
      s1_valid = 1'b1; s1_last = 1'b1; s1_data = DATA_WIDTH'(tag1);
      m_ready  = 1'b1;
      #1;
      check($sformatf("t3[%0d] s0_ready", k), s0_ready, (k % 2) == 0);
      h0 = s0_ready; h1 = s1_ready;
      @(posedge clk);
      #1;
      check($sformatf("t3[%0d] m_valid", k), m_valid, 1'b1);
      check($sformatf("t3[%0d] m_grant", k), m_grant, (k % 2) == 1);
      check($sformatf("t3[%0d] m_data", k), m_data[15:0], (k % 2 == 1) ? tag1 : tag0);
      if (h0) tag0++;
      if (h1) tag1++;
    end
    check("t3 cnt0", pkt_cnt0, 10);
    check("t3 cnt1", pkt_cnt1, 10);

    // 4: s1 holds its 5-beat packet while s0 waits, under random backpressure.
    reset_dut();
    for (int b = 0; b < 5; b++) exp_q.push_back('{16'h0301 + 16'(b), 1'b1, b == 4});
    for (int b = 0; b < 2; b++) exp_q.push_back('{16'h0401 + 16'(b), 1'b0, b == 1});
    i0 = 0; i1 = 0; cyc = 0; stall_prev = 1'b0;
    sv_tag = '0; sv_grant = 1'b0; sv_last = 1'b0;
    while (exp_q.size() > 0 && cyc < 300) begin
      @(negedge clk);
      m_ready  = (cyc < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      s1_valid = (i1 < 5);
      s1_last  = (i1 == 4);
      s1_data  = DATA_WIDTH'(16'h0301 + 16'(i1));
      s0_valid = (cyc >= 2) && (i0 < 2);
      s0_last  = (i0 == 1);
      s0_data  = DATA_WIDTH'(16'h0401 + 16'(i0));
      #1;
      if (stall_prev) begin
        check($sformatf("t4 c%0d stall m_data", cyc), m_data[15:0], sv_tag);
        check($sformatf("t4 c%0d stall m_grant", cyc), m_grant, sv_grant);
        check($sformatf("t4 c%0d stall m_last", cyc), m_last, sv_last);
      end
      if (m_valid && m_ready) begin
        e = exp_q.pop_front();
        check($sformatf("t4 c%0d m_data", cyc), m_data[15:0], e.tag);
        check($sformatf("t4 c%0d m_grant", cyc), m_grant, e.grant);
        check($sformatf("t4 c%0d m_last", cyc), m_last, e.last);
      end
      if (i1 > 0 && i1 < 5) check($sformatf("t4 c%0d s0_ready", cyc), s0_ready, 1'b0);
      stall_prev = m_valid && !m_ready;
      sv_tag = m_data[15:0]; sv_grant = m_grant; sv_last = m_last;
      h0 = s0_valid && s0_ready;
      h1 = s1_valid && s1_ready;
      @(posedge clk);
      if (h0) i0++;
      if (h1) i1++;
      cyc++;
    end
    check("t4 beats outstanding", exp_q.size(), 0);

    // 5: s0 stalls mid-packet; the lock holds and s1 waits.
    reset_dut();
    tbl.push_back(mk(1,0,16'h0051, 1,1,16'h0061, 1, 1,0, 1,0,0,16'h0051));
    tbl.push_back(mk(1,0,16'h0052, 1,1,16'h0061, 1, 1,0, 1,0,0,16'h0052));
    tbl.push_back(mk(0,0,16'h0000, 1,1,16'h0061, 1, 1,0, 0,0,0,16'h0000));
    tbl.push_back(mk(0,0,16'h0000, 1,1,16'h0061, 1, 1,0, 0,0,0,16'h0000));
    tbl.push_back(mk(0,0,16'h0000, 1,1,16'h0061, 1, 1,0, 0,0,0,16'h0000));
    tbl.push_back(mk(1,0,16'h0053, 1,1,16'h0061, 1, 1,0, 1,0,0,16'h0053));
    tbl.push_back(mk(1,1,16'h0054, 1,1,16'h0061, 1, 1,0, 1,0,1,16'h0054));
    tbl.push_back(mk(0,0,16'h0000, 1,1,16'h0061, 1, 0,1, 1,1,1,16'h0061));
    tbl.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 1, 1,0, 0,0,0,16'h0000));
    run_table("t5");
    check("t5 cnt0", pkt_cnt0, 1);
    check("t5 cnt1", pkt_cnt1, 1);

    // 6: asynchronous reset in the middle of a packet.
    reset_dut();
    apply_vec(mk(1,1,16'h0071, 0,0,16'h0, 1, 1,0, 1,0,1,16'h0071), "t6 single");
    apply_vec(mk(1,0,16'h0072, 0,0,16'h0, 1, 1,0, 1,0,0,16'h0072), "t6 first");
    check("t6 cnt0 pre", pkt_cnt0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6 rst m_valid", m_valid, 1'b0);
    check("t6 rst cnt0", pkt_cnt0, 0);
    check("t6 rst m_data", m_data[15:0], 16'h0000);
    check("t6 rst s0_ready", s0_ready, 1'b0);
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    rst_n = 1'b1;
    apply_vec(mk(1,1,16'h0081, 1,1,16'h0091, 1, 1,0, 1,0,1,16'h0081), "t6 contend");
    apply_vec(mk(0,0,16'h0000, 1,1,16'h0091, 1, 0,1, 1,1,1,16'h0091), "t6 s1");
    check("t6 cnt0 post", pkt_cnt0, 1);
    check("t6 cnt1 post", pkt_cnt1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
